one_shot: RTL and testbench

//  Edge-triggered monostable: a rising edge on trig produces a registered pulse on y

---
 rtl/one_shot.sv | 76 +++++++
 tb/tb_one_shot.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/one_shot.sv
// Edge-triggered monostable: a trig rising edge yields a PULSE_LEN-cycle registered pulse on y.
// Define ONE_SHOT_IGNORE_CNT_EN to add the ignored_cnt output counting discarded/restarting edges.
module one_shot #(
    parameter  int PULSE_LEN     = 6,
    parameter  int RETRIGGERABLE = 0,
    localparam int CNT_W         = $clog2(PULSE_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    output logic             y,
    output logic [CNT_W-1:0] remaining
`ifdef ONE_SHOT_IGNORE_CNT_EN
    ,
    output logic [15:0]      ignored_cnt
`endif
);

    generate
        if (PULSE_LEN < 1) begin : g_bad_pulse_len
            $error("one_shot: PULSE_LEN must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(PULSE_LEN);

    logic             trig_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             y_q;
    logic             rise;

    // A rise during an active window either restarts it or is thrown away,
    // depending on RETRIGGERABLE; the count itself never wraps below zero.
    always_comb begin
        rise  = trig & ~trig_q;
        cnt_d = '0;
        if (rise && ((cnt_q == '0) || (RETRIGGERABLE != 0))) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
        end else begin
            trig_q <= trig;
            cnt_q  <= cnt_d;
            y_q    <= (cnt_d != '0);
        end
    end

    assign y         = y_q;
    assign remaining = cnt_q;

`ifdef ONE_SHOT_IGNORE_CNT_EN
    logic [15:0] ign_q;

    // Rises while active are discards in one mode and restarts in the other;
    // either way they are counted, saturating rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ign_q <= '0;
        end else if (rise && (cnt_q != '0) && (ign_q != 16'hFFFF)) begin
            ign_q <= ign_q + 16'd1;
        end
    end

    assign ignored_cnt = ign_q;
`endif

endmodule

// File: tb/tb_one_shot.sv
// Directed bench for one_shot: one non-retriggerable and one retriggerable instance
// share clk/rst/trig; expected remaining/y values are hand-computed tables plus a cycle model.
module tb_one_shot;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic       yN;
    logic       yR;
    logic [2:0] remN;
    logic [2:0] remR;
`ifdef ONE_SHOT_IGNORE_CNT_EN
    logic [15:0] ignN;
    logic [15:0] ignR;
`endif

    one_shot #(.PULSE_LEN(6), .RETRIGGERABLE(0)) dutN (
        .clk(clk), .rst(rst), .trig(trig), .y(yN), .remaining(remN)
`ifdef ONE_SHOT_IGNORE_CNT_EN
        , .ignored_cnt(ignN)
`endif
    );

    one_shot #(.PULSE_LEN(6), .RETRIGGERABLE(1)) dutR (
        .clk(clk), .rst(rst), .trig(trig), .y(yR), .remaining(remR)
`ifdef ONE_SHOT_IGNORE_CNT_EN
        , .ignored_cnt(ignR)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int trigV[16];
    int expN[16];
    int expR[16];

    int mq;
    int cn;
    int cr;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Drive trig away from the active edge, then sample just after the edge.
    task automatic applyStimulus(input logic t);
        @(negedge clk);
        trig = t;
        @(posedge clk);
        #1;
    endtask

    task automatic runSeq(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(trigV[k] != 0);
            checkOutput($sformatf("%s remN k%0d", name, k), int'(remN), expN[k]);
            checkOutput($sformatf("%s yN k%0d", name, k), int'(yN), int'(expN[k] != 0));
            checkOutput($sformatf("%s remR k%0d", name, k), int'(remR), expR[k]);
            checkOutput($sformatf("%s yR k%0d", name, k), int'(yR), int'(expR[k] != 0));
        end
    endtask

    task automatic checkBoth(input string name, input int rN, input int rR);
        checkOutput({name, " remN"}, int'(remN), rN);
        checkOutput({name, " yN"}, int'(yN), int'(rN != 0));
        checkOutput({name, " remR"}, int'(remR), rR);
        checkOutput({name, " yR"}, int'(yR), int'(rR != 0));
    endtask

    task automatic stepModel(input int t);
        int rise;
        rise = (t != 0 && mq == 0) ? 1 : 0;
        mq   = t;
        if (rise != 0 && cn == 0) cn = 6;
        else if (cn != 0) cn = cn - 1;
        if (rise != 0) cr = 6;
        else if (cr != 0) cr = cr - 1;
    endtask

    initial begin
        rst  = 1'b1;
        trig = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkBoth("reset", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single one-cycle trigger.
        trigV = '{default: 0};
        trigV[0] = 1;
        expN = '{6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expR = expN;
        runSeq("t1", 8);

        // Rises at E, E+3, E+6.
        trigV = '{default: 0};
        trigV[0] = 1;
        trigV[3] = 1;
        trigV[6] = 1;
        expN = '{6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expR = '{6, 5, 4, 6, 5, 4, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0};
        runSeq("t2", 14);
`ifdef ONE_SHOT_IGNORE_CNT_EN
        checkOutput("t2 ignN", int'(ignN), 2);
        checkOutput("t2 ignR", int'(ignR), 2);
`endif

        // Level-held trigger gives one pulse.
        trigV = '{default: 0};
        for (int k = 0; k < 10; k++) trigV[k] = 1;
        expN = '{6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expR = expN;
        runSeq("t3", 12);

        // Back-to-back pulses with the minimum one low cycle.
        trigV = '{default: 0};
        trigV[0] = 1;
        trigV[7] = 1;
        expN = '{6, 5, 4, 3, 2, 1, 0, 6, 5, 4, 3, 2, 1, 0, 0, 0};
        expR = expN;
        runSeq("t4", 15);

        // Asynchronous reset mid-pulse, then release with trig low and high.
        applyStimulus(1'b1);
        checkBoth("t5 E", 6, 6);
        applyStimulus(1'b0);
        checkBoth("t5 E+1", 5, 5);
        #2;
        rst = 1'b1;
        #1;
        checkBoth("t5 async", 0, 0);
        @(posedge clk);
        #1;
        checkBoth("t5 held", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0);
        checkBoth("t5 rel0 a", 0, 0);
        applyStimulus(1'b0);
        checkBoth("t5 rel0 b", 0, 0);
        @(negedge clk);
        rst  = 1'b1;
        trig = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkBoth("t5 rel1", 6, 6);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0);
        checkBoth("t5 drain", 0, 0);

        // Random bursts against the cycle model.
        mq = 0;
        cn = 0;
        cr = 0;
        for (int b = 0; b < 50; b++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 2);
            lo = $urandom_range(1, 4);
            for (int c = 0; c < hi + lo; c++) begin
                int t;
                t = (c < hi) ? 1 : 0;
                stepModel(t);
                applyStimulus(t != 0);
                checkBoth($sformatf("t6 b%0d c%0d", b, c), cn, cr);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
